// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-ported data memory between requester ports A and B
module data_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter bit PRIO_A  = 1'b0,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  input  logic [3:0]        a_mask,
  output logic [31:0]       a_rdata,
  output logic              a_done,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  input  logic [3:0]        b_mask,
  output logic [31:0]       b_rdata,
  output logic              b_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [3:0]        mem_mask,
  input  logic              mem_stall,
  input  logic [31:0]       mem_rdata,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;
  state_t     state;
  logic       owner;
  logic       we;
  logic       last_grant;
  logic [3:0] cnt;
  logic       pick_b;
  logic       sel_we;
  logic       tmo;
  // owner/last_grant encoding: 0 = port A, 1 = port B; pick_b only matters when some req is high
  assign pick_b = PRIO_A ? !a_req : (a_req && b_req) ? !last_grant : !a_req;
  assign sel_we = pick_b ? b_we : a_we;
  // the abort fires on the edge that ends the TIMEOUT-th waiting cycle
  assign tmo    = (TIMEOUT != 0) && (cnt == 4'(TIMEOUT - 1));
  // transaction sequencer: grant, one-cycle strobe, stall handshake, done pulse, timeout abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      we         <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_mask   <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (a_req || b_req) begin
          owner      <= pick_b;
          last_grant <= pick_b;
          we         <= sel_we;
          mem_addr   <= pick_b ? b_addr : a_addr;
          mem_wdata  <= pick_b ? b_wdata : a_wdata;
          mem_mask   <= pick_b ? b_mask : a_mask;
          mem_read   <= !sel_we;
          mem_write  <= sel_we;
          state      <= ISSUE;
        end
        ISSUE: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          cnt       <= '0;
          state     <= WAIT_HI;
        end
        WAIT_HI, WAIT_LO: begin
          cnt <= cnt + 4'd1;
          if (tmo) begin
            err <= 1'b1;
            if (owner) begin
              b_rdata <= 32'hDEAD_BEEF;
              b_done  <= 1'b1;
            end else begin
              a_rdata <= 32'hDEAD_BEEF;
              a_done  <= 1'b1;
            end
            state <= DONE;
          end else if (state == WAIT_HI && mem_stall) begin
            state <= WAIT_LO;
          end else if (state == WAIT_LO && !mem_stall) begin
            if (!we && owner) b_rdata <= mem_rdata;
            if (!we && !owner) a_rdata <= mem_rdata;
            b_done <= owner;
            a_done <= !owner;
            state  <= DONE;
          end
        end
        DONE: begin
          a_done <= 1'b0;
          b_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: scoreboard bench for a round-robin and a fixed-priority arbiter
module tb_data_mem_arbiter;
  typedef struct {bit inst; bit port; logic [31:0] data;} exp_t;
  exp_t q[$];
  int n_assert = 0, n_fail = 0, n_done = 0, exp_done = 0;
  int rd_cyc0 = 0, wr_cyc0 = 0;
  logic clk = 1'b0, rst_n = 1'b0, never_stall = 1'b0;
  logic a_we = 1'b0, b_we = 1'b0;
  logic [31:0] a_addr = '0, b_addr = '0, a_wdata = '0, b_wdata = '0;
  logic [3:0] a_mask = '0, b_mask = '0;
  logic a_req0 = 1'b0, b_req0 = 1'b0, a_req1 = 1'b0, b_req1 = 1'b0;
  logic [31:0] a_rdata0, b_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic [31:0] a_rdata1, b_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic a_done0, b_done0, mem_write0, mem_read0, mem_stall0, err0;
  logic a_done1, b_done1, mem_write1, mem_read1, mem_stall1, err1;
  logic [3:0] mem_mask0, mem_mask1;
  logic [7:0] mc0 = '0, mc1 = '0;
  always #5 clk = ~clk;
  data_mem_arbiter #(.ADDR_W(32), .PRIO_A(1'b0), .TIMEOUT(15)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req0), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_mask(a_mask),
    .a_rdata(a_rdata0), .a_done(a_done0),
    .b_req(b_req0), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_mask(b_mask),
    .b_rdata(b_rdata0), .b_done(b_done0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_write(mem_write0), .mem_read(mem_read0),
    .mem_mask(mem_mask0), .mem_stall(mem_stall0), .mem_rdata(mem_rdata0), .err(err0));
  data_mem_arbiter #(.ADDR_W(32), .PRIO_A(1'b1), .TIMEOUT(15)) u_pa (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req1), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_mask(a_mask),
    .a_rdata(a_rdata1), .a_done(a_done1),
    .b_req(b_req1), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_mask(b_mask),
    .b_rdata(b_rdata1), .b_done(b_done1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_write(mem_write1), .mem_read(mem_read1),
    .mem_mask(mem_mask1), .mem_stall(mem_stall1), .mem_rdata(mem_rdata1), .err(err1));
  function automatic logic [31:0] mfun(logic [31:0] a);
    return (a == 32'h1004) ? 32'h1234_5678 : {a[15:0], 16'hA5A5};
  endfunction
  // memory models: stall rises the cycle after the strobe and stays high for two cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc0 <= '0;
      mc1 <= '0;
    end else begin
      mc0 <= (mem_read0 || mem_write0) ? 8'd1 : (mc0 != 0 && mc0 != 8'hFF) ? mc0 + 8'd1 : mc0;
      mc1 <= (mem_read1 || mem_write1) ? 8'd1 : (mc1 != 0 && mc1 != 8'hFF) ? mc1 + 8'd1 : mc1;
    end
  end
  assign mem_stall0 = !never_stall && mc0 >= 8'd1 && mc0 <= 8'd2;
  assign mem_stall1 = !never_stall && mc1 >= 8'd1 && mc1 <= 8'd2;
  assign mem_rdata0 = mfun(mem_addr0);
  assign mem_rdata1 = mfun(mem_addr1);
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push(bit inst, bit port, logic [31:0] d);
    q.push_back('{inst, port, d});
    exp_done++;
  endtask
  task automatic observe(bit inst, logic ad, logic bd, logic [31:0] ar, logic [31:0] br);
    exp_t e;
    if (ad || bd) begin
      n_done++;
      if (q.size() == 0) chk("spurious_done_queue_size", 32'(q.size()), 32'd1);
      else begin
        e = q.pop_front();
        chk("done_inst", 32'(inst), 32'(e.inst));
        chk("done_port", 32'(bd), 32'(e.port));
        chk("single_done", 32'(ad && bd), 32'd0);
        chk("done_rdata", bd ? br : ar, e.data);
      end
    end
  endtask
  // scoreboard monitor and strobe counters, sampled mid-cycle
  always @(negedge clk) begin
    observe(1'b0, a_done0, b_done0, a_rdata0, b_rdata0);
    observe(1'b1, a_done1, b_done1, a_rdata1, b_rdata1);
    if (mem_read0) rd_cyc0++;
    if (mem_write0) wr_cyc0++;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_dones(int budget);
    for (int i = 0; i < budget && n_done < exp_done; i++) begin
      @(negedge clk);
      #1;
    end
    chk("done_count", 32'(n_done), 32'(exp_done));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [4:0] pat;
    int first, wr0, rd0;
    logic e16;
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem_read", 32'(mem_read0), 32'd0);
    chk("rst_a_done", 32'(a_done0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_mem_addr", mem_addr0, 32'd0);
    // A read at 0x1004: done exactly in cycle 5 after the sampling edge
    step();
    a_we = 1'b0; a_addr = 32'h1004; a_mask = 4'hF;
    push(1'b0, 1'b0, 32'h1234_5678);
    a_req0 = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      pat[i-1] = a_done0;
    end
    chk("a_read_done_pattern", 32'(pat), 32'b10000);
    step();
    a_req0 = 1'b0;
    wait_dones(10);
    chk("a_read_strobe_cycles", 32'(rd_cyc0), 32'd1);
    // B write: single write strobe, address/data/mask held through DONE
    b_we = 1'b1; b_addr = 32'h1008; b_wdata = 32'hCAFE_F00D; b_mask = 4'h2;
    wr0 = wr_cyc0; rd0 = rd_cyc0;
    push(1'b0, 1'b1, 32'h0);
    b_req0 = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      pat[i-1] = b_done0;
      chk("w_mem_addr", mem_addr0, 32'h1008);
      chk("w_mem_wdata", mem_wdata0, 32'hCAFE_F00D);
    end
    chk("w_mem_mask", 32'(mem_mask0), 32'h2);
    chk("b_write_done_pattern", 32'(pat), 32'b10000);
    step();
    b_req0 = 1'b0; b_we = 1'b0;
    wait_dones(10);
    chk("w_write_strobe_cycles", 32'(wr_cyc0 - wr0), 32'd1);
    chk("w_no_read_strobe", 32'(rd_cyc0 - rd0), 32'd0);
    chk("a_rdata_held", a_rdata0, 32'h1234_5678);
    // timeout: stall never rises, abort after 15 waiting cycles
    never_stall = 1'b1;
    a_addr = 32'h1010;
    push(1'b0, 1'b0, 32'hDEAD_BEEF);
    a_req0 = 1'b1;
    first = 0; e16 = 1'bx;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 16) e16 = err0;
      if (a_done0) begin
        first = i;
        break;
      end
    end
    chk("tmo_done_cycle", 32'(first), 32'd17);
    chk("tmo_err_before", 32'(e16), 32'd0);
    chk("tmo_err_set", 32'(err0), 32'd1);
    step();
    a_req0 = 1'b0;
    never_stall = 1'b0;
    wait_dones(10);
    repeat (3) step();
    chk("tmo_err_sticky", 32'(err0), 32'd1);
    // reset during WAIT_LO: outputs clear asynchronously, transaction is lost
    a_addr = 32'h1004;
    a_req0 = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    a_req0 = 1'b0;
    #1;
    chk("arst_mem_addr", mem_addr0, 32'd0);
    chk("arst_a_rdata", a_rdata0, 32'd0);
    chk("arst_err", 32'(err0), 32'd0);
    chk("arst_strobes", 32'({mem_read0, mem_write0, a_done0, b_done0}), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    // round-robin from reset with both held: A, B, A, B
    a_addr = 32'h3000; b_addr = 32'h4000;
    push(1'b0, 1'b0, mfun(32'h3000));
    push(1'b0, 1'b1, mfun(32'h4000));
    push(1'b0, 1'b0, mfun(32'h3000));
    push(1'b0, 1'b1, mfun(32'h4000));
    a_req0 = 1'b1; b_req0 = 1'b1;
    wait_dones(100);
    step();
    a_req0 = 1'b0; b_req0 = 1'b0;
    chk("rr_err_clear", 32'(err0), 32'd0);
    // fixed priority: A starves B while held, B served once A drops
    a_addr = 32'h5000; b_addr = 32'h6000;
    repeat (3) push(1'b1, 1'b0, mfun(32'h5000));
    a_req1 = 1'b1; b_req1 = 1'b1;
    wait_dones(100);
    step();
    a_req1 = 1'b0;
    push(1'b1, 1'b1, mfun(32'h6000));
    wait_dones(50);
    step();
    b_req1 = 1'b0;
    repeat (5) step();
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("pa_err_clear", 32'(err1), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
